// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware FIFO for the router output channels.
// Words carry a header tag bit. The read side decodes the packet length from
// each popped header and counts down the words left in the current packet.
module router_fifo_pkt #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AFULL_TH = DEPTH - 2,
  parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_hdr,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic [DATA_W-2:0] pkt_left,
  output logic              pkt_done,
  output logic              ovf,
  output logic              udf
);

  logic [DATA_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [DATA_W:0]  rd_word;

  // Status flags come straight from the registered occupancy.
  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign almost_full = (32'(count) >= AFULL_TH);
  assign empty       = (count == '0);

  // Accepted accesses; a flush cycle accepts nothing.
  assign push    = wr_en & ~full  & ~soft_rst;
  assign pop     = rd_en & ~empty & ~soft_rst;
  assign rd_word = mem[rd_ptr];

  // Storage array: tag in the top bit, no reset (stale words are unreachable).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {lfd_state, d_in};
    end
  end

  // Pointers, occupancy and access-error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (soft_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      ovf <= wr_en & full;
      udf <= rd_en & empty;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Read data register and per-packet word countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout     <= '0;
      dout_hdr <= 1'b0;
      pkt_left <= '0;
      pkt_done <= 1'b0;
    end else if (soft_rst) begin
      dout     <= '0;
      dout_hdr <= 1'b0;
      pkt_left <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (pop) begin
        dout     <= rd_word[DATA_W-1:0];
        dout_hdr <= rd_word[DATA_W];
        if (rd_word[DATA_W]) begin
          // Header: payload length from bits [DATA_W-1:2], plus the parity word.
          pkt_left <= {1'b0, rd_word[DATA_W-1:2]} + (DATA_W-1)'(1);
        end else if (pkt_left != '0) begin
          pkt_left <= pkt_left - (DATA_W-1)'(1);
          pkt_done <= (pkt_left == (DATA_W-1)'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Bench for router_fifo_pkt: directed scenarios plus random traffic, all
// checked against a queue-based model of the FIFO and its packet counter.
module tb_router_fifo_pkt;

  logic       clk = 1'b0;
  logic       rst;
  logic       soft_rst, wr_en, lfd_state, rd_en;
  logic [7:0] d_in;
  logic [7:0] dout;
  logic       dout_hdr, full, almost_full, empty, pkt_done, ovf, udf;
  logic [4:0] count;
  logic [6:0] pkt_left;

  // Wide instance for the parameter sweep.
  logic        b_soft_rst, b_wr_en, b_lfd, b_rd_en;
  logic [15:0] b_d_in, b_dout;
  logic        b_hdr, b_full, b_af, b_empty, b_done, b_ovf, b_udf;
  logic [6:0]  b_count;
  logic [14:0] b_pkt_left;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [8:0] q[$];
  int         pl;
  logic [7:0] m_dout;
  logic       m_hdr, m_done, m_ovf, m_udf;

  always #5 clk = ~clk;

  router_fifo_pkt u_dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .wr_en(wr_en),
    .lfd_state(lfd_state), .d_in(d_in), .rd_en(rd_en), .dout(dout),
    .dout_hdr(dout_hdr), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count), .pkt_left(pkt_left), .pkt_done(pkt_done),
    .ovf(ovf), .udf(udf)
  );

  router_fifo_pkt #(.DATA_W(16), .DEPTH(64), .AFULL_TH(60)) u_dut2 (
    .clk(clk), .rst(rst), .soft_rst(b_soft_rst), .wr_en(b_wr_en),
    .lfd_state(b_lfd), .d_in(b_d_in), .rd_en(b_rd_en), .dout(b_dout),
    .dout_hdr(b_hdr), .full(b_full), .almost_full(b_af),
    .empty(b_empty), .count(b_count), .pkt_left(b_pkt_left), .pkt_done(b_done),
    .ovf(b_ovf), .udf(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pl = 0; m_dout = '0; m_hdr = 1'b0;
    m_done = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // One clock of FIFO behaviour, decided from the occupancy before the edge.
  task automatic model_step(input logic w, input logic l, input logic [7:0] d,
                            input logic r, input logic s);
    logic       was_full, was_empty;
    logic [8:0] it;
    was_full  = (q.size() == 16);
    was_empty = (q.size() == 0);
    m_done = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    if (s) begin
      model_reset();
    end else begin
      m_ovf = w & was_full;
      m_udf = r & was_empty;
      if (r && !was_empty) begin
        it = q.pop_front();
        m_dout = it[7:0];
        m_hdr  = it[8];
        if (it[8]) begin
          pl = int'(it[7:2]) + 1;
        end else if (pl > 0) begin
          pl = pl - 1;
          m_done = (pl == 0);
        end
      end
      if (w && !was_full) q.push_back({l, d});
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},     32'(dout),        32'(m_dout));
    chk({tag, ".dout_hdr"}, 32'(dout_hdr),    32'(m_hdr));
    chk({tag, ".count"},    32'(count),       32'(q.size()));
    chk({tag, ".full"},     32'(full),        32'(q.size() == 16));
    chk({tag, ".afull"},    32'(almost_full), 32'(q.size() >= 14));
    chk({tag, ".empty"},    32'(empty),       32'(q.size() == 0));
    chk({tag, ".pkt_left"}, 32'(pkt_left),    32'(pl));
    chk({tag, ".pkt_done"}, 32'(pkt_done),    32'(m_done));
    chk({tag, ".ovf"},      32'(ovf),         32'(m_ovf));
    chk({tag, ".udf"},      32'(udf),         32'(m_udf));
  endtask

  // Drive one cycle, let the edge happen, then compare against the model.
  task automatic cyc(input string tag, input logic w, input logic l,
                     input logic [7:0] d, input logic r, input logic s);
    wr_en = w; lfd_state = l; d_in = d; rd_en = r; soft_rst = s;
    @(posedge clk);
    #1;
    model_step(w, l, d, r, s);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; soft_rst = 1'b0; wr_en = 1'b0; lfd_state = 1'b0; d_in = '0; rd_en = 1'b0;
    b_soft_rst = 1'b0; b_wr_en = 1'b0; b_lfd = 1'b0; b_d_in = '0; b_rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Put some state in, then drop rst asynchronously in the middle of a write
    cyc("pre_rst", 1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    cyc("pre_rst", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    wr_en = 1'b1; d_in = 8'h99;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    wr_en = 1'b0;
    rst = 1'b1;
    cyc("idle_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf_pulse", 32'(udf), 32'd1);
    cyc("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, overflow once, drain in order
    for (int i = 1; i <= 17; i++) cyc("fill", 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      cyc("drain", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_order", 32'(dout), 32'(i));
    end
    cyc("drained", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Pointer wrap, then simultaneous access at full and at empty
    for (int i = 0; i < 10; i++) cyc("wrap_w", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("wrap_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cyc("wrap_w2", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    cyc("both_full", 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
    chk("both_full_cnt", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) cyc("wrap_r2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("both_empty", 1'b1, 1'b0, 8'hDD, 1'b1, 1'b0);
    chk("both_empty_cnt", 32'(count), 32'd1);
    cyc("both_empty_rd", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("both_empty_dout", 32'(dout), 32'hDD);

    // Packet of length 5: header, 5 payload, 1 parity
    cyc("pkt_h", 1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("pkt_w", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    cyc("pkt_rh", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pkt_left_hdr", 32'(pkt_left), 32'd6);
    for (int i = 0; i < 6; i++) cyc("pkt_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pkt_done_last", 32'(pkt_done), 32'd1);
    cyc("pkt_after", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // soft_rst in the middle of a packet, together with a write
    cyc("srst_h", 1'b1, 1'b1, 8'h14, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("srst_w", 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("srst_r", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cyc("srst", 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1);
    chk("srst_cnt", 32'(count), 32'd0);
    cyc("srst_push", 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    cyc("srst_pop", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("srst_first", 32'(dout), 32'h55);

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 250; i++) begin
        cyc("rand",
            1'($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30)),
            1'($urandom_range(0, 7) == 0),
            8'($urandom),
            1'($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75)),
            1'($urandom_range(0, 127) == 0));
      end
    end

    // Wide instance: almost_full at 60, full at 64, long header
    for (int i = 1; i <= 64; i++) begin
      b_wr_en = 1'b1;
      b_lfd   = (i == 1);
      b_d_in  = (i == 1) ? 16'hFFFC : 16'(i);
      @(posedge clk);
      #1;
      if (i == 59) chk("w_af59", 32'(b_af), 32'd0);
      if (i == 60) chk("w_af60", 32'(b_af), 32'd1);
      if (i == 63) chk("w_full63", 32'(b_full), 32'd0);
      if (i == 64) chk("w_full64", 32'(b_full), 32'd1);
    end
    b_wr_en = 1'b0;
    b_lfd   = 1'b0;
    b_rd_en = 1'b1;
    @(posedge clk);
    #1;
    b_rd_en = 1'b0;
    chk("w_pkt_left", 32'(b_pkt_left), 32'h4000);
    chk("w_hdr", 32'(b_hdr), 32'd1);
    chk("w_dout", 32'(b_dout), 32'hFFFC);
    chk("w_count", 32'(b_count), 32'd63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
